// File: rtl/data_memory_if.sv
// Request/response bundle between the memory stage and data_memory.
// The master holds active and its qualifiers stable until ready.
interface data_memory_if;
    logic        active;
    logic        rw;
    logic [31:0] indexData;
    logic [31:0] inputMem;
    logic [31:0] outputMem;
    logic        ready;
    logic        stall;
    logic        error;

    modport master (
        output active, rw, indexData, inputMem,
        input  outputMem, ready, stall, error
    );

    modport slave (
        input  active, rw, indexData, inputMem,
        output outputMem, ready, stall, error
    );
endinterface

// File: rtl/data_memory.sv
// Word RAM, one request in flight: access LATENCY edges after accept, ready/outputMem the cycle after.
// No overlap: stall freezes the requester until RESP; DMEM_ALIGN_CHECK_EN flags and suppresses misaligned accesses.
module data_memory #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    data_memory_if.slave  s
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cnt;
    logic          r_rw;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_ready;
    logic          r_error;
    logic [31:0]   r_mem [DEPTH];

    logic          w_accept;
    logic          w_access;
    logic          w_misal;
    logic          w_wr;
    logic [AW-1:0] w_word;
    logic          w_unused_addr;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_access = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (s.active) begin
                    w_next   = ST_BUSY;
                    w_accept = 1'b1;
                end
            end
            ST_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_next   = ST_RESP;
                    w_access = 1'b1;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Upper address bits fold away so addresses wrap modulo DEPTH*4.
    assign w_word        = r_addr[AW+1:2];
    assign w_unused_addr = ^r_addr;

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misal = (r_addr[1:0] != 2'b00);
`else
    assign w_misal = 1'b0;
`endif

    // Reset drops the state to IDLE asynchronously, so an interrupted store never writes.
    assign w_wr = w_access && r_rw && !w_misal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_rw    <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_ready <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= w_access;
            r_error <= w_access && w_misal;
            if (w_accept) begin
                r_rw    <= s.rw;
                r_addr  <= s.indexData;
                r_wdata <= s.inputMem;
                r_cnt   <= 4'(LATENCY - 1);
            end else if ((r_state == ST_BUSY) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access && (w_misal || !r_rw)) begin
                r_rdata <= w_misal ? 32'h0 : r_mem[w_word];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_word] <= r_wdata;
        end
    end

    assign s.outputMem = r_rdata;
    assign s.ready     = r_ready;
    assign s.error     = r_error;
    assign s.stall     = rst_n && ((r_state == ST_BUSY) || ((r_state == ST_IDLE) && s.active));
endmodule

// File: tb/tb_data_memory.sv
// Directed and randomized checks of data_memory against an array model of the RAM.
module tb_data_memory;
    localparam int DEP = 256;
    localparam int LAT = 2;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    data_memory_if bus ();

    data_memory #(.DEPTH(DEP), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] ref_mem [DEP];
    logic [31:0] exp_out = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete request; called just after a rising edge with the DUT idle.
    task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d, input bit perturb);
        bit mis;
        int idx;
        mis = ALIGN_EN && (a[1:0] != 2'b00);
        idx = int'((a >> 2) % DEP);
        bus.active    = 1'b1;
        bus.rw        = w;
        bus.indexData = a;
        bus.inputMem  = d;
        #1 chk("stall_on_request", bus.stall, 1);
        @(posedge clk); #1;
        if (perturb) begin
            bus.inputMem  = 32'h2222_2222;
            bus.indexData = 32'h0000_000C;
        end
        for (int k = 0; k < LAT; k++) begin
            chk("busy_stall", bus.stall, 1);
            chk("busy_ready", bus.ready, 0);
            @(posedge clk); #1;
        end
        if (mis)    exp_out = 32'h0;
        else if (w) ref_mem[idx] = d;
        else        exp_out = ref_mem[idx];
        chk("resp_ready", bus.ready, 1);
        chk("resp_stall", bus.stall, 0);
        chk("resp_data", bus.outputMem, exp_out);
        chk("resp_error", bus.error, mis);
        bus.active = 1'b0;
        @(posedge clk); #1;
        chk("post_ready", bus.ready, 0);
        chk("post_error", bus.error, 0);
    endtask

    initial begin
        int          nrdy;
        logic        prev_rdy;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;

        rst_n         = 1'b0;
        bus.active    = 1'b1;
        bus.rw        = 1'b0;
        bus.indexData = 32'h0;
        bus.inputMem  = 32'h0;
        #3;
        chk("rst_ready", bus.ready, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_data", bus.outputMem, 32'h0);
        chk("rst_error", bus.error, 0);
        bus.active = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < DEP; i++) xact(1'b1, 32'(i * 4), $urandom, 1'b0);

        // Reset while a store is in flight.
        bus.active    = 1'b1;
        bus.rw        = 1'b1;
        bus.indexData = 32'h10;
        bus.inputMem  = 32'h1234_5678;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", bus.ready, 0);
        chk("midrst_stall", bus.stall, 0);
        chk("midrst_data", bus.outputMem, 32'h0);
        bus.active = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_out = 32'h0;
        @(posedge clk); #1;
        xact(1'b0, 32'h10, 32'h0, 1'b0);

        xact(1'b1, 32'h40, 32'hCAFE_F00D, 1'b0);
        xact(1'b0, 32'h40, 32'h0, 1'b0);
        xact(1'b1, 32'h0000_0404, 32'hA5A5_A5A5, 1'b0);
        xact(1'b0, 32'h0000_0004, 32'h0, 1'b0);
        xact(1'b1, 32'h8, 32'h1111_1111, 1'b1);
        xact(1'b0, 32'h8, 32'h0, 1'b0);
        xact(1'b0, 32'hC, 32'h0, 1'b0);
        xact(1'b1, 32'h42, 32'hDEAD_BEEF, 1'b0);
        xact(1'b0, 32'h40, 32'h0, 1'b0);

        // Held active: a new request every LAT+2 cycles, never back-to-back ready.
        bus.active    = 1'b1;
        bus.rw        = 1'b0;
        bus.indexData = 32'h20;
        nrdy          = 0;
        prev_rdy      = 1'b0;
        for (int i = 1; i <= 4 * (LAT + 2); i++) begin
            @(posedge clk); #1;
            if (bus.ready === 1'b1) nrdy++;
            chk("held_consecutive", prev_rdy & bus.ready, 0);
            prev_rdy = bus.ready;
        end
        bus.active = 1'b0;
        exp_out    = ref_mem[8];
        chk("held_count", 32'(nrdy), 32'd4);
        chk("held_data", bus.outputMem, exp_out);
        @(posedge clk); #1;
        chk("held_idle_ready", bus.ready, 0);
        chk("held_idle_stall", bus.stall, 0);

        for (int i = 0; i < 60; i++) begin
            w = 1'($urandom_range(0, 1));
            a = $urandom;
            d = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            xact(w, a, d, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/data_memory.md
# data_memory

Word-organised data RAM behind the pipeline's memory stage. It accepts one load or store request at a time through an `active`/`ready` handshake and performs the array access after a programmable latency. It returns read data on `outputMem` and holds `stall` high while an access is in flight, so the pipeline can freeze the memory stage.

## Interface
Parameters:
- `DEPTH`, 256: number of 32-bit words; power of two, at least 2.
- `LATENCY`, 2: rising edges from request acceptance to the access edge; range 1..15.

Ports:
- `clk`  in  1  rising-edge clock, the only clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `active`  in  1  request valid; the requester holds it and its qualifiers stable until `ready`.
- `rw`  in  1  operation select; 1 = store, 0 = load.
- `indexData`  in  32  byte address.
- `inputMem`  in  32  store data.
- `outputMem`  out  32  load data; registered.
- `ready`  out  1  one-cycle completion pulse; registered.
- `stall`  out  1  high while state is BUSY or (IDLE with `active` high).
- `error`  out  1  misaligned-access flag, valid with `ready`; registered.

## Operation
- State machine with three states: IDLE, BUSY, RESP.
- **IDLE:**
  - When `active`=1 at a rising edge, capture `rw`, `indexData` and `inputMem`.
  - Load the down-counter with LATENCY-1 (4 bits) and go to BUSY.
  - When `active`=0, stay in IDLE.
- **BUSY:**
  - While the counter is not 0, decrement it on each edge.
  - When the counter is 0, perform the access on that edge and go to RESP.
  - Store: write the captured data to `mem[word]`; `outputMem` keeps its previous value.
  - Load: `outputMem` is loaded with `mem[word]`.
- **RESP:** `ready`=1 for exactly this cycle. `active` is ignored. The next edge always returns to IDLE.
- Word index is `indexData[log2(DEPTH)+1:2]`. Higher address bits are ignored, so addresses wrap modulo DEPTH×4.
- Captured request fields are immune to input changes after acceptance.
- `active` held high through RESP is re-accepted in the following IDLE cycle as a new request.
- **Reset:**
  - Applies at any state, including mid-access, and forces IDLE.
  - Reset values: `ready`=0, `error`=0, `outputMem`=32'h0, counter=0.
  - An interrupted store does not write the array.
  - RAM contents are not reset.
- `stall` is combinational from state and `active`. It is 0 in RESP and 0 during reset.

## Timing
- Accept at edge E. The access happens at edge E+LATENCY.
- `ready` and `outputMem` are valid in the cycle after edge E+LATENCY.
- Back-to-back throughput is one request per LATENCY+2 cycles.
- Example with LATENCY=1: accept at edge 0, access at edge 1, `ready` high between edges 1 and 2, IDLE after edge 2.
- Store followed by a load to the same word returns the stored value; there is no bypass requirement because accesses are serialised.
- `error` and `ready` rise and fall together.

## Configuration
- Macro: `DMEM_ALIGN_CHECK_EN`.
- **Defined:**
  - When captured `indexData[1:0]` is not 2'b00, the access edge suppresses the array write.
  - `outputMem` is loaded with 32'h0.
  - `error`=1 during RESP. `ready` still pulses and timing is unchanged.
- **Undefined:** `indexData[1:0]` is ignored, and `error` is tied to 0.

## Test plan
- Reset mid-flight: assert `rst_n`=0 while in BUSY with a store of 32'h1234_5678 to 0x10, then load 0x10 → old contents returned; `ready`=0, `stall`=0 and `outputMem`=0 during reset.
- Store/load with LATENCY=2: store 32'hCAFE_F00D to 0x40 accepted at edge 0, then load 0x40 → `ready` pulses after edge 2 for each request; the load returns CAFE_F00D; `stall`=1 from request until RESP.
- Wrap-around with DEPTH=256: store 32'hA5A5_A5A5 to 0x0000_0404, load 0x0000_0004 → returns A5A5_A5A5.
- Input change after accept: accept a store of 32'h1111_1111 to 0x8, then change `inputMem` to 2222_2222 and `indexData` to 0xC during BUSY → word 0x8 = 1111_1111, word 0xC unchanged.
- Held `active`: keep `active`=1 through RESP → exactly one `ready` per LATENCY+2 cycles, never two consecutive `ready` cycles.
- Alignment with `DMEM_ALIGN_CHECK_EN`: store to 0x42 → `error`=1 with `ready`, a load of 0x40 is unchanged, and `outputMem`=0; without the macro the same store writes word 0x40 and `error`=0.
